fifo2sl_ctrl: RTL and testbench

//  Transceiver-side consumer of the APB bridge's async command FIFO (34-bit words {modifier[1:0], payload[31:0]}).

---
 rtl/fifo2sl_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_fifo2sl_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2sl_ctrl.sv
// fifo2sl_ctrl: pops command words, updates cfg/channel or launches a TX, and pushes echoes, status and RX data back.
// Latency: a command is popped 1 cycle after it is seen; cfg/channel apply and echo-push 1 cycle after the pop.
// Backpressure: stops popping while a TX is in flight; rsp_full holds every pending response flag.
//
// Ports: clk/rst (async, active high); cmd_empty/cmd_data/cmd_inc (FWFT command FIFO read side);
//        rsp_full/rsp_data/rsp_inc (response FIFO write side); cfg, channel (applied registers);
//        tx_data/tx_start/tx_busy (SL core TX handshake); rx_data/rx_valid (SL core RX strobe).
// Optional build macro FIFO2SL_TIMEOUT_EN adds a TX watchdog of TX_TIMEOUT cycles (status bit 3).
module fifo2sl_ctrl #(
    parameter int CONFIG_REG_WIDTH  = 16,
    parameter int STATUS_REG_WIDTH  = 16,
    parameter int CHANNEL_REG_WIDTH = 2,
    parameter int TX_TIMEOUT        = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_empty,
    input  logic [33:0]                  cmd_data,
    output logic                         cmd_inc,
    input  logic                         rsp_full,
    output logic [33:0]                  rsp_data,
    output logic                         rsp_inc,
    output logic [CONFIG_REG_WIDTH-1:0]  cfg,
    output logic [CHANNEL_REG_WIDTH-1:0] channel,
    output logic [31:0]                  tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    input  logic [31:0]                  rx_data,
    input  logic                         rx_valid
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_DECODE    = 4'b0010,
        S_TX_LAUNCH = 4'b0100,
        S_TX_WAIT   = 4'b1000
    } state_t;

    state_t                         state_q, state_d;
    logic [33:0]                    cmd_q, cmd_d;
    logic                           cmd_inc_q, cmd_inc_d;
    logic [CONFIG_REG_WIDTH-1:0]    cfg_q, cfg_d;
    logic [CHANNEL_REG_WIDTH-1:0]   channel_q, channel_d;
    logic [31:0]                    tx_data_q, tx_data_d;
    logic                           tx_start_q, tx_start_d;
    logic                           busy_seen_q, busy_seen_d;
    logic [31:0]                    rx_buf_q, rx_buf_d;
    logic                           pend_rx_q, pend_rx_d;
    logic                           pend_stat_q, pend_stat_d;
    logic                           pend_cfg_q, pend_cfg_d;
    logic                           pend_chn_q, pend_chn_d;
    logic                           rx_ovf_q, rx_ovf_d;
    logic                           tx_to_q, tx_to_d;

    // Event strobes from the FSM into the pending-flag logic
    logic                           fsm_set_cfg, fsm_set_chn, fsm_set_stat, fsm_set_to;

    // Arbiter grants and response mux
    logic                           gnt_rx, gnt_stat, gnt_cfg, gnt_chn;
    logic                           rx_ovf_set;
    logic [STATUS_REG_WIDTH-1:0]    status_word;
    logic [31:0]                    status_ext, cfg_ext, chn_ext;
    logic [33:0]                    rsp_data_c;

`ifdef FIFO2SL_TIMEOUT_EN
    logic [15:0]                    to_cnt_q, to_cnt_d;
`else
    // The watchdog limit has no effect when the watchdog is not built.
    logic                           unused_timeout;
    assign unused_timeout = (TX_TIMEOUT != 0);
`endif

    //------------------------------------------------------------------
    // Command FSM
    //------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_inc_d    = 1'b0;
        cfg_d        = cfg_q;
        channel_d    = channel_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        busy_seen_d  = busy_seen_q;
        fsm_set_cfg  = 1'b0;
        fsm_set_chn  = 1'b0;
        fsm_set_stat = 1'b0;
        fsm_set_to   = 1'b0;
`ifdef FIFO2SL_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // FWFT: the word is valid while not empty; latch it now and
                // pop during DECODE, so the FIFO head only moves once.
                if (!cmd_empty) begin
                    cmd_d     = cmd_data;
                    cmd_inc_d = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (cmd_q[33:32])
                    2'd0: begin
                        cfg_d       = cmd_q[CONFIG_REG_WIDTH-1:0];
                        fsm_set_cfg = 1'b1;
                    end
                    2'd1: begin
                        tx_data_d = cmd_q[31:0];
                        state_d   = S_TX_LAUNCH;
                    end
                    2'd2: fsm_set_stat = 1'b1;
                    default: begin
                        channel_d   = cmd_q[CHANNEL_REG_WIDTH-1:0];
                        fsm_set_chn = 1'b1;
                    end
                endcase
            end
            S_TX_LAUNCH: begin
                if (!tx_busy) begin
                    tx_start_d  = 1'b1;
                    busy_seen_d = 1'b0;
                    state_d     = S_TX_WAIT;
`ifdef FIFO2SL_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end
            end
            S_TX_WAIT: begin
                // Completion is the falling edge of tx_busy after it was seen high.
                if (tx_busy) begin
                    busy_seen_d = 1'b1;
                end else if (busy_seen_q) begin
                    fsm_set_stat = 1'b1;
                    state_d      = S_IDLE;
                end
`ifdef FIFO2SL_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 16'd1;
                if ((state_d == S_TX_WAIT) && (to_cnt_q == 16'(TX_TIMEOUT - 1))) begin
                    fsm_set_to   = 1'b1;
                    fsm_set_stat = 1'b1;
                    state_d      = S_IDLE;
                end
`else
                // Without the watchdog a stuck core holds the FSM here.
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Response arbiter and pending flags
    //------------------------------------------------------------------
    always_comb begin
        status_word    = '0;
        status_word[0] = tx_busy;
        status_word[1] = pend_rx_q;
        status_word[2] = rx_ovf_q;
        status_word[3] = tx_to_q;

        status_ext = '0;
        status_ext[STATUS_REG_WIDTH-1:0] = status_word;
        cfg_ext = '0;
        cfg_ext[CONFIG_REG_WIDTH-1:0] = cfg_q;
        chn_ext = '0;
        chn_ext[CHANNEL_REG_WIDTH-1:0] = channel_q;

        gnt_rx   = pend_rx_q & ~rsp_full;
        gnt_stat = pend_stat_q & ~pend_rx_q & ~rsp_full;
        gnt_cfg  = pend_cfg_q & ~pend_stat_q & ~pend_rx_q & ~rsp_full;
        gnt_chn  = pend_chn_q & ~pend_cfg_q & ~pend_stat_q & ~pend_rx_q & ~rsp_full;

        // Mux sources are all registers (tx_busy apart); the push itself is
        // combinational so that rsp_full is honoured in the very cycle it rises.
        rsp_data_c = '0;
        if (gnt_rx)        rsp_data_c = {2'd1, rx_buf_q};
        else if (gnt_stat) rsp_data_c = {2'd2, status_ext};
        else if (gnt_cfg)  rsp_data_c = {2'd0, cfg_ext};
        else if (gnt_chn)  rsp_data_c = {2'd3, chn_ext};

        // An RX word still waiting (not leaving this cycle) is overwritten.
        rx_ovf_set = rx_valid & pend_rx_q & ~gnt_rx;
        rx_buf_d   = rx_valid ? rx_data : rx_buf_q;

        // Set beats clear: a slot refreshed while being pushed goes out again.
        pend_rx_d   = (pend_rx_q   & ~gnt_rx)   | rx_valid;
        pend_stat_d = (pend_stat_q & ~gnt_stat) | fsm_set_stat | rx_ovf_set;
        pend_cfg_d  = (pend_cfg_q  & ~gnt_cfg)  | fsm_set_cfg;
        pend_chn_d  = (pend_chn_q  & ~gnt_chn)  | fsm_set_chn;
        rx_ovf_d    = (rx_ovf_q    & ~gnt_stat) | rx_ovf_set;
        tx_to_d     = (tx_to_q     & ~gnt_stat) | fsm_set_to;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            cmd_inc_q   <= 1'b0;
            cfg_q       <= '0;
            channel_q   <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            busy_seen_q <= 1'b0;
            rx_buf_q    <= '0;
            pend_rx_q   <= 1'b0;
            pend_stat_q <= 1'b0;
            pend_cfg_q  <= 1'b0;
            pend_chn_q  <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_to_q     <= 1'b0;
`ifdef FIFO2SL_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_inc_q   <= cmd_inc_d;
            cfg_q       <= cfg_d;
            channel_q   <= channel_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            busy_seen_q <= busy_seen_d;
            rx_buf_q    <= rx_buf_d;
            pend_rx_q   <= pend_rx_d;
            pend_stat_q <= pend_stat_d;
            pend_cfg_q  <= pend_cfg_d;
            pend_chn_q  <= pend_chn_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_to_q     <= tx_to_d;
`ifdef FIFO2SL_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign cmd_inc  = cmd_inc_q;
    assign rsp_inc  = gnt_rx | gnt_stat | gnt_cfg | gnt_chn;
    assign rsp_data = rsp_data_c;
    assign cfg      = cfg_q;
    assign channel  = channel_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

endmodule

// File: tb/tb_fifo2sl_ctrl.sv
// tb_fifo2sl_ctrl: directed and randomized checks of fifo2sl_ctrl against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: drives rsp_full directly; the command FIFO is a bench-side FWFT queue.
module tb_fifo2sl_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_empty;
    logic [33:0] cmd_data;
    logic        cmd_inc;
    logic        rsp_full;
    logic [33:0] rsp_data;
    logic        rsp_inc;
    logic [15:0] cfg;
    logic [1:0]  channel;
    logic [31:0] tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [31:0] rx_data;
    logic        rx_valid;

    int errors = 0;
    int checks = 0;

    logic [33:0] cmd_fifo[$];
    logic [33:0] got[$];
    logic [31:0] tx_got[$];
    int          tx_starts = 0;
    int          cmd_pops  = 0;

    int busy_len  = 3;
    bit busy_rand = 1'b0;

    always #5 clk = ~clk;

    fifo2sl_ctrl #(.TX_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_empty(cmd_empty), .cmd_data(cmd_data), .cmd_inc(cmd_inc),
        .rsp_full(rsp_full), .rsp_data(rsp_data), .rsp_inc(rsp_inc),
        .cfg(cfg), .channel(channel),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    // FWFT command FIFO model plus response/TX monitor, all on the falling edge.
    initial begin
        cmd_empty = 1'b1;
        cmd_data  = '0;
        forever begin
            @(negedge clk);
            if (rsp_inc) got.push_back(rsp_data);
            if (tx_start) begin
                tx_starts++;
                tx_got.push_back(tx_data);
            end
            if (cmd_inc) begin
                cmd_pops++;
                if (cmd_fifo.size() > 0) void'(cmd_fifo.pop_front());
            end
            cmd_empty = (cmd_fifo.size() == 0);
            cmd_data  = cmd_empty ? 34'h0 : cmd_fifo[0];
        end
    end

    // SL core model: busy rises one edge after tx_start, stays up for a while.
    initial begin
        int n;
        int lim;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                lim = busy_rand ? int'($urandom_range(1, 4)) : 0;
                n   = 0;
                @(posedge clk); #1;
                tx_busy = 1'b1;
                while (!rst && n < (busy_rand ? lim : busy_len)) begin
                    @(posedge clk); #1;
                    n++;
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk); #1;
    endtask

    task automatic wait_rsp(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            samp();
            if (got.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic wait_tx_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            samp();
            if (tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_full = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) tick();
        samp();
        checks++; if (cmd_inc !== 1'b0)  begin errors++; $display("FAIL reset_cmd_inc got=%b exp=0", cmd_inc); end
        checks++; if (rsp_inc !== 1'b0)  begin errors++; $display("FAIL reset_rsp_inc got=%b exp=0", rsp_inc); end
        checks++; if (rsp_data !== 34'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (cfg !== 16'h0)     begin errors++; $display("FAIL reset_cfg got=%h exp=0", cfg); end
        checks++; if (channel !== 2'h0)  begin errors++; $display("FAIL reset_channel got=%h exp=0", channel); end
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
        tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_config();
        bit ok;
        got.delete();
        cmd_fifo.push_back({2'd0, 32'h0000_00A5});
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            samp();
            if (cmd_inc === 1'b1) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL cfg_pop got=none exp=cmd_inc pulse"); end
        samp();
        checks++; if (cmd_inc !== 1'b0) begin errors++; $display("FAIL cfg_pop_width got=%b exp=0", cmd_inc); end
        checks++; if (cfg !== 16'h00A5) begin errors++; $display("FAIL cfg_value got=%h exp=00a5", cfg); end
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL cfg_echo got=none exp=%h", {2'd0, 32'hA5}); end
        else if (got[0] !== {2'd0, 32'h0000_00A5}) begin errors++; $display("FAIL cfg_echo got=%h exp=%h", got[0], {2'd0, 32'hA5}); end
    endtask

    task automatic test_tx();
        bit ok;
        int starts0;
        busy_rand = 1'b0; busy_len = 5;
        repeat (3) tick();
        got.delete();
        starts0 = tx_starts;
        cmd_fifo.push_back({2'd1, 32'hDEAD_BEEF});
        wait_tx_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_start got=none exp=pulse"); end
        checks++; if (tx_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tx_data got=%h exp=deadbeef", tx_data); end
        checks++; if (got.size() != 0) begin errors++; $display("FAIL tx_early_rsp got=%0d exp=0 words", got.size()); end
        samp();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_start_width got=%b exp=0", tx_start); end
        wait_rsp(1, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tx_status got=none exp=%h", {2'd2, 32'h0}); end
        else if (got[0] !== {2'd2, 32'h0}) begin errors++; $display("FAIL tx_status got=%h exp=%h", got[0], {2'd2, 32'h0}); end
        checks++; if (tx_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tx_data_hold got=%h exp=deadbeef", tx_data); end
        checks++; if (tx_starts - starts0 != 1) begin errors++; $display("FAIL tx_start_count got=%0d exp=1", tx_starts - starts0); end
    endtask

    task automatic test_rsp_full();
        bit ok;
        tick();
        rsp_full = 1'b1;
        got.delete();
        cmd_fifo.push_back({2'd3, 32'h0000_0002});
        repeat (4) tick();
        rx_data = 32'h1234; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; rx_data = '0;
        repeat (10) tick();
        samp();
        checks++; if (got.size() != 0) begin errors++; $display("FAIL full_hold got=%0d exp=0 words", got.size()); end
        checks++; if (channel !== 2'd2) begin errors++; $display("FAIL channel_value got=%h exp=2", channel); end
        tick();
        rsp_full = 1'b0;
        wait_rsp(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_release got=%0d exp=2 words", got.size()); end
        else begin
            if (got[0] !== {2'd1, 32'h1234}) begin errors++; $display("FAIL full_first got=%h exp=%h", got[0], {2'd1, 32'h1234}); end
            checks++;
            if (got[1] !== {2'd3, 32'h2}) begin errors++; $display("FAIL full_second got=%h exp=%h", got[1], {2'd3, 32'h2}); end
        end
        repeat (5) samp();
        checks++; if (got.size() != 2) begin errors++; $display("FAIL full_extra got=%0d exp=2 words", got.size()); end
    endtask

    task automatic test_rx_overflow();
        bit ok;
        tick();
        rsp_full = 1'b1;
        got.delete();
        rx_valid = 1'b1; rx_data = 32'h11;
        tick();
        rx_data = 32'h22;
        tick();
        rx_valid = 1'b0; rx_data = '0;
        repeat (3) tick();
        rsp_full = 1'b0;
        wait_rsp(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_release got=%0d exp=2 words", got.size()); end
        else begin
            if (got[0] !== {2'd1, 32'h22}) begin errors++; $display("FAIL ovf_rx got=%h exp=%h", got[0], {2'd1, 32'h22}); end
            checks++;
            if (got[1] !== {2'd2, 32'h4}) begin errors++; $display("FAIL ovf_status got=%h exp=%h", got[1], {2'd2, 32'h4}); end
        end
        // Sticky overflow must be gone once reported; payload of a poll is ignored.
        tick();
        got.delete();
        cmd_fifo.push_back({2'd2, 32'hFFFF_FFFF});
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sticky_clear got=none exp=%h", {2'd2, 32'h0}); end
        else if (got[0] !== {2'd2, 32'h0}) begin errors++; $display("FAIL sticky_clear got=%h exp=%h", got[0], {2'd2, 32'h0}); end
    endtask

    task automatic test_reset_mid_tx();
        bit ok;
        busy_rand = 1'b0; busy_len = 50;
        got.delete();
        cmd_fifo.push_back({2'd1, 32'h0000_CAFE});
        wait_tx_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_tx_start got=none exp=pulse"); end
        repeat (4) tick();
        rst = 1'b1;
        samp();
        checks++;
        if ({cmd_inc, rsp_inc, tx_start} !== 3'b000 || rsp_data !== 34'h0 ||
            cfg !== 16'h0 || channel !== 2'h0 || tx_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_tx got=inc%b/%b start%b rsp%h cfg%h ch%h tx%h exp=all zero",
                     cmd_inc, rsp_inc, tx_start, rsp_data, cfg, channel, tx_data);
        end
        repeat (3) tick();
        rst = 1'b0;
        busy_len = 3;
        repeat (2) tick();
        got.delete();
        cmd_fifo.push_back({2'd0, 32'h0000_005A});
        wait_rsp(1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_recover got=none exp=%h", {2'd0, 32'h5A}); end
        else if (got[0] !== {2'd0, 32'h5A}) begin errors++; $display("FAIL rst_recover got=%h exp=%h", got[0], {2'd0, 32'h5A}); end
        checks++; if (cfg !== 16'h005A) begin errors++; $display("FAIL rst_recover_cfg got=%h exp=005a", cfg); end
    endtask

`ifdef FIFO2SL_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        busy_rand = 1'b0; busy_len = 100000;
        got.delete();
        cmd_fifo.push_back({2'd1, 32'h0000_0077});
        wait_rsp(1, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_status got=none exp=%h", {2'd2, 32'h9}); end
        else if (got[0] !== {2'd2, 32'h9}) begin errors++; $display("FAIL timeout_status got=%h exp=%h", got[0], {2'd2, 32'h9}); end
        busy_len = 0;
        repeat (5) tick();
    endtask
`endif

    // Random command mix with the response FIFO never full: every command
    // yields exactly one response, in command order.
    task automatic test_random();
        bit          ok;
        logic [33:0] exp_rsp[$];
        logic [31:0] exp_tx[$];
        logic [15:0] m_cfg;
        logic [1:0]  m_chn;
        logic [31:0] p;
        int          mod;
        m_cfg = cfg;
        m_chn = channel;
        busy_rand = 1'b1;
        rsp_full  = 1'b0;
        tick();
        got.delete();
        tx_got.delete();
        for (int k = 0; k < 40; k++) begin
            mod = int'($urandom_range(0, 3));
            p   = $urandom;
            cmd_fifo.push_back({mod[1:0], p});
            case (mod)
                0: begin m_cfg = p[15:0]; exp_rsp.push_back({2'd0, 16'h0, p[15:0]}); end
                1: begin exp_tx.push_back(p); exp_rsp.push_back({2'd2, 32'h0}); end
                2: exp_rsp.push_back({2'd2, 32'h0});
                default: begin m_chn = p[1:0]; exp_rsp.push_back({2'd3, 30'h0, p[1:0]}); end
            endcase
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_rsp(exp_rsp.size(), 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_count got=%0d exp=%0d words", got.size(), exp_rsp.size()); end
        repeat (5) samp();
        for (int i = 0; i < exp_rsp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_rsp[i]) begin errors++; $display("FAIL rand_rsp[%0d] got=%h exp=%h", i, got[i], exp_rsp[i]); end
        end
        checks++; if (tx_got.size() != exp_tx.size()) begin errors++; $display("FAIL rand_tx_count got=%0d exp=%0d", tx_got.size(), exp_tx.size()); end
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) begin
            checks++;
            if (tx_got[i] !== exp_tx[i]) begin errors++; $display("FAIL rand_tx[%0d] got=%h exp=%h", i, tx_got[i], exp_tx[i]); end
        end
        checks++; if (cfg !== m_cfg)     begin errors++; $display("FAIL rand_cfg got=%h exp=%h", cfg, m_cfg); end
        checks++; if (channel !== m_chn) begin errors++; $display("FAIL rand_channel got=%h exp=%h", channel, m_chn); end
        busy_rand = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rsp_full = 1'b0; rx_valid = 1'b0; rx_data = '0;
        test_reset();
        test_config();
        test_tx();
        test_rsp_full();
        test_rx_overflow();
        test_reset_mid_tx();
`ifdef FIFO2SL_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
